// File: rtl/serial_display_receiver_pkg.sv
// Shared display constants: frame geometry, bit ordering and serial line indices.
// Digit 0 is shifted first and lands in the MSB byte of the frame.
package serial_display_receiver_pkg;
   localparam int FRAME_BITS_DEF = 32;
   localparam int DIGITS         = 4;
   localparam int SEG_BITS       = 8;

   // segment bit positions within one digit byte (a is shifted first)
   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   localparam int LINE_DATA  = 0;
   localparam int LINE_CLK   = 1;
   localparam int LINE_LATCH = 2;
   localparam int NUM_LINES  = 3;

   function automatic int digit_lsb(input int digit);
      return (DIGITS - 1 - digit) * SEG_BITS;
   endfunction
endpackage

// File: rtl/serial_display_receiver_sync_edge_detect.sv
// Multi-flop synchroniser for one async line plus a history flop for rising-edge detect.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_async,
   output logic o_level,
   output logic o_rise
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign o_level = sync_q[SYNC_STAGES-1];
   assign o_rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/serial_display_receiver.sv
// Rebuilds the parallel segment frame from the three-wire display stream,
// mimicking an external latching shift-register chain.
module serial_display_receiver
   import serial_display_receiver_pkg::*;
#(
   parameter int FRAME_BITS  = FRAME_BITS_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_en,
   input  logic                  i_serial_data,
   input  logic                  i_serial_clk,
   input  logic                  i_serial_latch,
   output logic [FRAME_BITS-1:0] o_segments,
   output logic                  o_frame_valid,
   output logic                  o_frame_error,
   output logic [7:0]            o_frame_count
);
   localparam int              CNT_W    = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FRAME_BITS + 1);

   logic [NUM_LINES-1:0]  line_pin, line_level, line_rise;
   logic [FRAME_BITS-1:0] shift_q, shift_nxt;
   logic [CNT_W-1:0]      cnt_q, cnt_nxt;
   logic                  shift_ev, latch_ev;
   logic                  unused_lines;

   always_comb begin
      line_pin             = '0;
      line_pin[LINE_DATA]  = i_serial_data;
      line_pin[LINE_CLK]   = i_serial_clk;
      line_pin[LINE_LATCH] = i_serial_latch;
   end

   // all three paths share the same depth, so synced data lines up with the synced clock edge
   for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
      sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .i_clk   (i_clk),
         .i_reset (i_reset),
         .i_async (line_pin[g]),
         .o_level (line_level[g]),
         .o_rise  (line_rise[g])
      );
   end

   assign unused_lines = ^{line_level[LINE_CLK], line_level[LINE_LATCH], line_rise[LINE_DATA]};

   assign shift_ev = i_en & line_rise[LINE_CLK];
   assign latch_ev = i_en & line_rise[LINE_LATCH];

   // shift resolves first so a coincident latch sees the post-shift state
   always_comb begin
      shift_nxt = shift_q;
      cnt_nxt   = cnt_q;
      if (shift_ev) begin
         shift_nxt = {shift_q[FRAME_BITS-2:0], line_level[LINE_DATA]};
         if (cnt_q != CNT_OVER) cnt_nxt = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         shift_q       <= '0;
         cnt_q         <= '0;
         o_segments    <= '0;
         o_frame_valid <= 1'b0;
         o_frame_error <= 1'b0;
         o_frame_count <= '0;
      end else begin
         o_frame_valid <= 1'b0;
         o_frame_error <= 1'b0;
         shift_q       <= shift_nxt;
         if (latch_ev) begin
            cnt_q <= '0;
            if (cnt_nxt == CNT_FULL) begin
               o_segments    <= shift_nxt;
               o_frame_valid <= 1'b1;
               o_frame_count <= o_frame_count + 8'd1;
            end else begin
               o_frame_error <= 1'b1;
            end
         end else begin
            cnt_q <= cnt_nxt;
         end
      end
   end
endmodule

// File: doc/serial_display_receiver.md
# serial_display_receiver

Receives the three-wire display stream (serial data, shift clock, latch) produced by the clock core's display shifter and reconstructs the parallel segment frame, behaving like the external latching shift-register chain. Used as the bench-side and on-chip loopback checker for the display path, and as a parallel display driver for FPGA builds without discrete shift registers. All three serial inputs are asynchronous to the system clock and are synchronised and edge-detected internally.

## Interface
- FRAME_BITS, 32, bits per display frame (4 digits x 8 segment bits)
- SYNC_STAGES, 2, flip-flop stages on each serial input (minimum 2)
- i_clk  input  1  system clock
- i_reset  input  1  asynchronous, active-high reset
- i_en  input  1  receive enable; low = ignore all serial edges, hold outputs
- i_serial_data  input  1  serial segment data, async
- i_serial_clk  input  1  shift clock, data sampled on its rising edge, async
- i_serial_latch  input  1  latch strobe, frame committed on its rising edge, async
- o_segments  output  FRAME_BITS  last committed frame; first bit shifted = MSB
- o_frame_valid  output  1  one-cycle pulse when a correct-length frame is committed
- o_frame_error  output  1  one-cycle pulse when a latch arrives with wrong bit count
- o_frame_count  output  8  count of committed frames, wraps 255 -> 0

## Operation
- Each serial input passes through SYNC_STAGES flops, then one extra flop for edge detection; rising edge = synced high and previous low.
- Shift edge (i_en high): shift register <= {shift[FRAME_BITS-2:0], synced data}; bit counter increments, saturating at FRAME_BITS+1 (overrun marker).
- Data sampled is the synced data value aligned with the synced clock edge (same pipeline depth on both paths).
- Latch edge (i_en high):
  - counter == FRAME_BITS: o_segments <= shift register, o_frame_valid pulse, o_frame_count increments.
  - otherwise (short or overrun): o_segments unchanged, o_frame_error pulse, count unchanged.
  - counter cleared to 0 in both cases; shift register not cleared.
- Shift and latch edge in the same cycle: shift applied first, latch evaluates the incremented count and commits the post-shift register contents.
- i_en low: edges discarded (detectors still track inputs so no stale edge fires when i_en rises); counter, shift register and outputs hold.
- Reset (any time, including mid-frame): synchroniser flops, shift register, counter, o_segments, o_frame_count = 0; o_frame_valid, o_frame_error = 0. Partial frame discarded.
- Synchronisers reset to 0, so a serial line already high at reset release produces one rising edge; senders hold lines low during reset.

## Timing
- Pin-to-edge-detect latency: SYNC_STAGES+1 i_clk cycles.
- o_segments, o_frame_valid/o_frame_error, o_frame_count update together, registered, SYNC_STAGES+1 cycles after latch rising edge at the pin (3 cycles at default).
- Pulses are exactly one i_clk cycle wide.
- Input requirement: each serial clk/latch high and low phase >= 2 i_clk cycles; data stable >= 2 i_clk cycles around serial clk rise. Violations are undetected, not flagged.
- Latch must follow the last shift edge by >= 1 i_clk cycle or be simultaneous (handled as above).

## Structure
- Shared display package/header: FRAME_BITS default, DIGITS=4, SEG_BITS=8, digit/segment bit ordering constants shared with the display shifter.
- Sub-module sync_edge_detect (parameter SYNC_STAGES; outputs synced level and rising-edge pulse), instantiated three times.
- Top holds shift register, saturating bit counter, commit/output registers, frame counter.

## Test plan
- Reset mid-frame: shift 10 bits, assert i_reset -> all outputs 0, next full 32-bit frame 0xA5C3_0F81 commits correctly.
- Nominal: shift 0xDEAD_BEEF MSB first, latch -> o_segments = 0xDEADBEEF 3 cycles after latch pin rise, o_frame_valid 1-cycle pulse, o_frame_count = 1.
- Short frame: 31 bits then latch -> o_frame_error pulse, o_segments unchanged, count unchanged; next 32-bit frame commits.
- Overrun: 40 bits then latch -> o_frame_error; counter cleared.
- Simultaneous: 31 bits, then 32nd shift edge and latch rise on same cycle -> commit with 32nd bit included, o_frame_valid.
- Enable/wrap: i_en low during a full frame -> no shift, no pulse; 256 valid frames -> o_frame_count wraps to 0.
